// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: one aligned load/store per request over a
// req/ack word port, with byte-lane steering, load extension and a wait-state timeout.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_force,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_err,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [3:0]        ext_be,
  output logic [31:0]       ext_wdata,
  input  logic              ext_ack,
  input  logic [31:0]       ext_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       size_q;
  logic             signed_q;
  logic [1:0]       lane_q;
  logic             illegal;
  logic             last_cycle;
  logic [3:0]       be_calc;
  logic [31:0]      wdata_calc;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_val;

  assign illegal = (mem_size == 2'b11) ||
                   (mem_size == 2'b01 && mem_addr[0]) ||
                   (mem_size == 2'b10 && mem_addr[1:0] != 2'b00);

  assign last_cycle = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    be_calc    = 4'b0000;
    wdata_calc = mem_wdata;
    case (mem_size)
      2'b00: begin
        be_calc    = 4'b0001 << mem_addr[1:0];
        wdata_calc = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{mem_wdata[15:0]}};
      end
      2'b10:   be_calc = 4'b1111;
      default: be_calc = 4'b0000;
    endcase
  end

  // Load extraction uses the latched lane/size so ext_rdata only matters at ack.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = ext_rdata[7:0];
      2'd1:    byte_sel = ext_rdata[15:8];
      2'd2:    byte_sel = ext_rdata[23:16];
      default: byte_sel = ext_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? ext_rdata[31:16] : ext_rdata[15:0];
    case (size_q)
      2'b00:   load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_val = ext_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mem_req) state_nxt = illegal ? S_DONE : S_REQ;
      S_REQ:   if (ext_ack || last_cycle) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_force = (state == S_REQ);
  assign ext_req   = (state == S_REQ);
  assign mem_done  = (state == S_DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      lane_q    <= 2'b00;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_be    <= 4'b0000;
      ext_wdata <= 32'h0;
      mem_rdata <= 32'h0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_req) begin
            cnt       <= '0;
            size_q    <= mem_size;
            signed_q  <= mem_signed;
            lane_q    <= mem_addr[1:0];
            ext_we    <= mem_we;
            ext_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
            ext_be    <= be_calc;
            ext_wdata <= wdata_calc;
            if (illegal) begin
              mem_err   <= 1'b1;
              mem_rdata <= 32'h0;
            end
          end
        end
        S_REQ: begin
          if (ext_ack) begin
            mem_err   <= 1'b0;
            mem_rdata <= ext_we ? 32'h0 : load_val;
          end else if (last_cycle) begin
            mem_err   <= 1'b1;
            mem_rdata <= 32'h0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed test-plan accesses plus random
// ones, expected completions queued by the driver and checked by a done monitor.
module tb_mem_stage_ctrl;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              mem_req, mem_we, mem_signed;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_force, mem_done, mem_err;
  logic [31:0]       mem_rdata;
  logic              ext_req, ext_we, ext_ack;
  logic [ADDR_W-1:0] ext_addr;
  logic [3:0]        ext_be;
  logic [31:0]       ext_wdata, ext_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];
  logic [32:0] last_exp = '0;

  mem_stage_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_force(mem_force), .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_be(ext_be),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every mem_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && mem_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL done_unexpected: got mem_done=1 expected no completion at %0t", $time);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("done_rdata", mem_rdata, e[31:0]);
        chk("done_err", {31'd0, mem_err}, {31'd0, e[32]});
      end
    end
  end

  // Reference behaviour written straight from the access rules.
  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input int a, input logic [31:0] rd);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // ack_cyc: REQ cycle (1..) in which ext_ack is driven; 0 or > TIMEOUT = never.
  task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_cyc, input bit spurious);
    int a;
    bit bad, acked;
    logic [3:0] e_be;
    logic [31:0] e_wd, e_rd;
    a = int'(addr);
    bad = (size == 2'b11) || (size == 2'b01 && a % 2 != 0) || (size == 2'b10 && a % 4 != 0);
    acked = !bad && ack_cyc >= 1 && ack_cyc <= TIMEOUT;
    if (size == 2'b00)      begin e_be = 4'(1 << (a % 4));              e_wd = {4{wd[7:0]}};  end
    else if (size == 2'b01) begin e_be = 4'(3 << (2 * ((a / 2) % 2))); e_wd = {2{wd[15:0]}}; end
    else                    begin e_be = 4'hF;                          e_wd = wd;            end
    e_rd = (acked && !we) ? model_load(size, sgn, a, rd) : 32'h0;
    last_exp = {!acked, e_rd};
    exp_q.push_back(last_exp);

    mem_req = 1'b1; mem_we = we; mem_size = size; mem_signed = sgn;
    mem_addr = addr; mem_wdata = wd;
    @(posedge clk); #1;
    mem_req = 1'b0;
    if (bad) begin
      chk("illegal_force", {31'd0, mem_force}, 32'd0);
      chk("illegal_ext_req", {31'd0, ext_req}, 32'd0);
    end else begin
      for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
        chk("req_ext_req", {31'd0, ext_req}, 32'd1);
        chk("req_force", {31'd0, mem_force}, 32'd1);
        chk("req_addr", 32'(ext_addr), 32'(addr & ~16'h3));
        chk("req_be", {28'd0, ext_be}, {28'd0, e_be});
        chk("req_we", {31'd0, ext_we}, {31'd0, we});
        if (we) chk("req_wdata", ext_wdata, e_wd);
        if (spurious) begin
          mem_req = 1'b1; mem_size = 2'b11; mem_addr = ADDR_W'($urandom);
        end
        ext_ack = (cyc == ack_cyc);
        ext_rdata = (cyc == ack_cyc) ? rd : $urandom;
        @(posedge clk); #1;
        mem_req = 1'b0; ext_ack = 1'b0;
        if (cyc == ack_cyc) break;
      end
    end
    chk("done_strobe", {31'd0, mem_done}, 32'd1);
    chk("done_force", {31'd0, mem_force}, 32'd0);
    chk("done_ext_req", {31'd0, ext_req}, 32'd0);
    @(posedge clk); #1;
    chk("idle_done", {31'd0, mem_done}, 32'd0);
    chk("hold_rdata", mem_rdata, last_exp[31:0]);
    chk("hold_err", {31'd0, mem_err}, {31'd0, last_exp[32]});
  endtask

  initial begin
    resetn = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_signed = 1'b0;
    mem_addr = '0; mem_wdata = '0; ext_ack = 1'b0; ext_rdata = '0;
    #12;
    chk("rst_force", {31'd0, mem_force}, 32'd0);
    chk("rst_done", {31'd0, mem_done}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_ext_req", {31'd0, ext_req}, 32'd0);
    chk("rst_ext_we", {31'd0, ext_we}, 32'd0);
    chk("rst_ext_addr", 32'(ext_addr), 32'h0);
    chk("rst_ext_be", {28'd0, ext_be}, 32'h0);
    chk("rst_ext_wdata", ext_wdata, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    access(1'b0, 2'b10, 1'b0, 16'h0104, 32'h0, 32'hCAFEBABE, 1, 1'b0);
    access(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, 32'h80FF0000, 4, 1'b0);
    access(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, 32'h80FF0000, 4, 1'b0);
    access(1'b1, 2'b01, 1'b0, 16'h0022, 32'h1234ABCD, 32'hFFFFFFFF, 2, 1'b0);
    access(1'b0, 2'b10, 1'b0, 16'h0002, 32'h0, 32'h0, 1, 1'b0);
    access(1'b0, 2'b01, 1'b0, 16'h0001, 32'h0, 32'h0, 1, 1'b0);
    access(1'b1, 2'b11, 1'b0, 16'h0000, 32'h5, 32'h0, 1, 1'b0);
    access(1'b0, 2'b10, 1'b0, 16'h0040, 32'h0, 32'h12345678, 0, 1'b0);
    access(1'b0, 2'b10, 1'b0, 16'h0040, 32'h0, 32'h12345678, 4, 1'b0);
    access(1'b0, 2'b01, 1'b1, 16'h0102, 32'h0, 32'h9ABC0000, 3, 1'b1);

    // Spurious ack while idle must not produce a completion.
    ext_ack = 1'b1; ext_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    ext_ack = 1'b0;
    @(posedge clk); #1;
    chk("idle_ack_ignored", {31'd0, mem_done}, 32'd0);

    // Reset in the second REQ cycle drops the access immediately.
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 16'h0200;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_ext_req", {31'd0, ext_req}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_ext_req", {31'd0, ext_req}, 32'd0);
    chk("rst_mid_force", {31'd0, mem_force}, 32'd0);
    chk("rst_mid_addr", 32'(ext_addr), 32'h0);
    chk("rst_mid_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 2'b00, 1'b1, 16'h0031, 32'h0, 32'h0000_7F00, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      access(1'($urandom), 2'($urandom), 1'($urandom), ADDR_W'($urandom), $urandom,
             $urandom, int'($urandom_range(0, TIMEOUT + 1)), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
